// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin EX/LSU arbiter for the integer register-file write port,
// with a busy scoreboard of pending destinations for decode RAW stalls.
module regfile_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int NUM_REGS = 32,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            busy_rs1,
  output logic            busy_rs2,
  input  logic            ex_valid,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            reg_wen,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] reg_in
);
  logic                r_last_lsu;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic                w_gnt;
  logic [AW-1:0]       w_rd;
  logic [XLEN-1:0]     w_data;
  always_comb begin
    ex_ready  = !rst && ex_valid && (!lsu_valid || r_last_lsu);
    lsu_ready = !rst && lsu_valid && (!ex_valid || !r_last_lsu);
    w_gnt     = ex_ready || lsu_ready;
    w_rd      = lsu_ready ? lsu_rd : ex_rd;
    w_data    = lsu_ready ? lsu_data : ex_data;
    w_set     = iss_valid ? NUM_REGS'(1) << iss_rd : '0;
    w_clr     = reg_wen ? NUM_REGS'(1) << rd : '0;
    busy_rs1  = r_busy[rs1] || (reg_wen && rd == rs1 && rs1 != '0);
    busy_rs2  = r_busy[rs2] || (reg_wen && rd == rs2 && rs2 != '0);
  end
  // Set is OR-ed after clear so a newer producer of the same index keeps it busy; bit 0 never sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wen    <= 1'b0;
      rd         <= '0;
      reg_in     <= '0;
      r_busy     <= '0;
      r_last_lsu <= 1'b0;
    end else begin
      reg_wen <= w_gnt && w_rd != '0;
      r_busy  <= ((r_busy & ~w_clr) | w_set) & ~NUM_REGS'(1);
      if (w_gnt) begin
        rd         <= w_rd;
        reg_in     <= w_data;
        r_last_lsu <= lsu_ready;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors; accepted writes queue expected results for a writeback monitor.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd, rs1, rs2, ex_rd, lsu_rd, rd;
  logic        busy_rs1, busy_rs2, ex_valid, ex_ready, lsu_valid, lsu_ready, reg_wen;
  logic [63:0] ex_data, lsu_data, reg_in;
  logic [68:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_data(ex_data), .ex_ready(ex_ready), .lsu_valid(lsu_valid), .lsu_rd(lsu_rd),
    .lsu_data(lsu_data), .lsu_ready(lsu_ready), .reg_wen(reg_wen), .rd(rd), .reg_in(reg_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [63:0] d);
    exp_q.push_back({r, d});
  endtask

  initial forever begin
    @(negedge clk);
    if (reg_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, want no write", rd, reg_in);
      end else chk("writeback", {rd, reg_in}, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; iss_valid = 0; iss_rd = 0; rs1 = 5; rs2 = 31;
    ex_valid = 0; ex_rd = 0; ex_data = 0; lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wen", reg_wen, 0); chk("rst_rd", rd, 0); chk("rst_reg_in", reg_in, 0);
    chk("rst_busy1", busy_rs1, 0); chk("rst_busy2", busy_rs2, 0);
    // EX only
    cyc(); ex_valid = 1; ex_rd = 5; ex_data = 64'h1234;
    @(negedge clk); chk("ex_only_ready", ex_ready, 1); chk("ex_only_lsu_ready", lsu_ready, 0);
    push(5, 64'h1234);
    // conflicts: LSU first after reset-state last_grant=EX, then alternate
    cyc(); ex_rd = 3; ex_data = 64'hA; lsu_valid = 1; lsu_rd = 4; lsu_data = 64'hB;
    @(negedge clk); chk("c1_lsu_ready", lsu_ready, 1); chk("c1_ex_ready", ex_ready, 0);
    push(4, 64'hB);
    cyc(); lsu_data = 64'hC;
    @(negedge clk); chk("c2_ex_ready", ex_ready, 1); chk("c2_lsu_ready", lsu_ready, 0);
    push(3, 64'hA);
    cyc(); ex_rd = 4; ex_data = 64'hD;
    @(negedge clk); chk("c3_lsu_ready", lsu_ready, 1); chk("c3_ex_ready", ex_ready, 0);
    push(4, 64'hC);
    cyc(); lsu_valid = 0;
    @(negedge clk); chk("c4_ex_ready", ex_ready, 1);
    push(4, 64'hD);
    cyc(); ex_valid = 0;
    cyc();
    @(negedge clk); chk("idle_wen", reg_wen, 0); chk("idle_hold", {rd, reg_in}, {5'd4, 64'hD});
    // x0 write
    cyc(); lsu_valid = 1; lsu_rd = 0; lsu_data = 64'hFF;
    @(negedge clk); chk("x0_ready", lsu_ready, 1);
    cyc(); lsu_valid = 0;
    @(negedge clk); chk("x0_wen", reg_wen, 0);
    // scoreboard set, hold through writeback, clear
    cyc(); iss_valid = 1; iss_rd = 7; rs1 = 7;
    cyc(); iss_valid = 0;
    @(negedge clk); chk("sb_busy_issued", busy_rs1, 1);
    cyc(); ex_valid = 1; ex_rd = 7; ex_data = 64'h77;
    @(negedge clk); chk("sb_busy_accept", busy_rs1, 1); chk("sb_ex_ready", ex_ready, 1);
    push(7, 64'h77);
    cyc(); ex_valid = 0;
    @(negedge clk); chk("sb_busy_wb", busy_rs1, 1);
    cyc();
    @(negedge clk); chk("sb_busy_cleared", busy_rs1, 0);
    // un-issued write still flags the writeback cycle
    cyc(); ex_valid = 1; ex_rd = 8; ex_data = 64'h88; rs2 = 8;
    @(negedge clk); chk("byp_busy_accept", busy_rs2, 0);
    push(8, 64'h88);
    cyc(); ex_valid = 0;
    @(negedge clk); chk("byp_busy_wb", busy_rs2, 1);
    cyc();
    @(negedge clk); chk("byp_busy_after", busy_rs2, 0);
    // set/clear collision on rd 9
    cyc(); iss_valid = 1; iss_rd = 9; rs1 = 9;
    cyc(); iss_valid = 0; ex_valid = 1; ex_rd = 9; ex_data = 64'h99;
    @(negedge clk); chk("col_ex_ready", ex_ready, 1);
    push(9, 64'h99);
    cyc(); ex_valid = 0; iss_valid = 1; iss_rd = 9;
    @(negedge clk); chk("col_busy_wb", busy_rs1, 1);
    cyc(); iss_valid = 0;
    @(negedge clk); chk("col_busy_after", busy_rs1, 1); chk("col_wen", reg_wen, 0);
    cyc();
    @(negedge clk); chk("col_busy_held", busy_rs1, 1);
    // mid-operation reset
    cyc(); iss_valid = 1; iss_rd = 2; rs1 = 2; rs2 = 6;
    cyc(); iss_rd = 6;
    cyc(); iss_valid = 0; ex_valid = 1; ex_rd = 12; ex_data = 64'hCC;
    @(negedge clk); chk("mr_busy1", busy_rs1, 1); chk("mr_busy2", busy_rs2, 1);
    chk("mr_pre_ready", ex_ready, 1);
    push(12, 64'hCC);
    cyc(); rst = 1; ex_rd = 10; ex_data = 64'hE0; lsu_valid = 1; lsu_rd = 11; lsu_data = 64'hE1;
    @(negedge clk); chk("mr_rst_ex_ready", ex_ready, 0); chk("mr_rst_lsu_ready", lsu_ready, 0);
    cyc(); rst = 0;
    @(negedge clk); chk("mr_wen", reg_wen, 0); chk("mr_busy1_clr", busy_rs1, 0);
    chk("mr_busy2_clr", busy_rs2, 0); chk("mr_lsu_first", lsu_ready, 1); chk("mr_ex_wait", ex_ready, 0);
    push(11, 64'hE1);
    cyc(); lsu_valid = 0;
    @(negedge clk); chk("mr_ex_next", ex_ready, 1);
    push(10, 64'hE0);
    cyc(); ex_valid = 0;
    repeat (3) cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
